// File: rtl/odometer_accum.sv
// Distance accumulator: a prescaled sample tick adds velocity into a fractional accumulator.
// Each completed unit pulses once and advances a saturating odometer plus wrapping trip counters.
module odometer_accum #(
  parameter int unsigned VEL_W    = 7,
  parameter int unsigned MOD      = 36000,
  parameter int unsigned TICK_DIV = 2500000,
  parameter int unsigned DIST_W   = 20,
  parameter int unsigned NUM_TRIP = 2,
  parameter int unsigned TRIP_MOD = 10000,
  localparam int unsigned FRAC_W  = $clog2(MOD),
  localparam int unsigned TRIP_W  = $clog2(TRIP_MOD)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [VEL_W-1:0]             velocity,
  input  logic [NUM_TRIP-1:0]          trip_clr,
  output logic                         unit_pulse,
  output logic [FRAC_W-1:0]            frac_out,
  output logic [DIST_W-1:0]            odo_total,
  output logic [NUM_TRIP*TRIP_W-1:0]   trip_count
);

  localparam int unsigned PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SUM_W  = FRAC_W + 1;

  logic [PCNT_W-1:0]                 pcnt_q, pcnt_d;
  logic [FRAC_W-1:0]                 frac_q, frac_d;
  logic                              unit_q, unit_d;
  logic [DIST_W-1:0]                 odo_q, odo_d;
  logic [NUM_TRIP-1:0][TRIP_W-1:0]   trip_q, trip_d;
  logic                              tick;
  logic [SUM_W-1:0]                  sum;
  logic                              carry;

  assign tick  = en && (pcnt_q == PCNT_W'(TICK_DIV - 1));
  // Full-width sum so the carry into the next unit is never lost.
  assign sum   = SUM_W'(frac_q) + SUM_W'(velocity);
  assign carry = sum >= SUM_W'(MOD);

  always_comb begin
    pcnt_d = pcnt_q;
    frac_d = frac_q;
    unit_d = 1'b0;
    odo_d  = odo_q;
    trip_d = trip_q;

    if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
    end

    if (tick) begin
      if (carry) begin
        frac_d = FRAC_W'(sum - SUM_W'(MOD));
        unit_d = 1'b1;
      end else begin
        frac_d = FRAC_W'(sum);
      end
    end

    if (unit_d && (odo_q != {DIST_W{1'b1}})) begin
      odo_d = odo_q + DIST_W'(1);
    end

    // A clear on the same edge as a unit wins for that trip only.
    for (int i = 0; i < int'(NUM_TRIP); i++) begin
      if (trip_clr[i]) begin
        trip_d[i] = '0;
      end else if (unit_d) begin
        trip_d[i] = (trip_q[i] == TRIP_W'(TRIP_MOD - 1)) ? '0 : trip_q[i] + TRIP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      frac_q <= '0;
      unit_q <= 1'b0;
      odo_q  <= '0;
      trip_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      frac_q <= frac_d;
      unit_q <= unit_d;
      odo_q  <= odo_d;
      trip_q <= trip_d;
    end
  end

  assign unit_pulse = unit_q;
  assign frac_out   = frac_q;
  assign odo_total  = odo_q;
  assign trip_count = trip_q;

endmodule

// File: tb/tb_odometer_accum.sv
// Directed bench: a fast-tick instance with default widths, plus a tiny-modulus instance
// for odometer saturation and trip wrap.
module tb_odometer_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: TICK_DIV=4, default widths
  logic        a_en = 1'b0;
  logic [6:0]  a_vel = '0;
  logic [1:0]  a_clr = '0;
  logic        a_pulse;
  logic [15:0] a_frac;
  logic [19:0] a_odo;
  logic [27:0] a_trip;

  odometer_accum #(
    .VEL_W(7), .MOD(36000), .TICK_DIV(4), .DIST_W(20), .NUM_TRIP(2), .TRIP_MOD(10000)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .velocity(a_vel), .trip_clr(a_clr),
    .unit_pulse(a_pulse), .frac_out(a_frac), .odo_total(a_odo), .trip_count(a_trip)
  );

  // Instance B: MOD=200, one tick per clk, 4-bit odometer, trips wrap at 20
  logic        b_en = 1'b0;
  logic [6:0]  b_vel = '0;
  logic [1:0]  b_clr = '0;
  logic        b_pulse;
  logic [7:0]  b_frac;
  logic [3:0]  b_odo;
  logic [9:0]  b_trip;

  odometer_accum #(
    .VEL_W(7), .MOD(200), .TICK_DIV(1), .DIST_W(4), .NUM_TRIP(2), .TRIP_MOD(20)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .velocity(b_vel), .trip_clr(b_clr),
    .unit_pulse(b_pulse), .frac_out(b_frac), .odo_total(b_odo), .trip_count(b_trip)
  );

  int total = 0;
  int bad   = 0;
  int npulse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int pulse, input int frac, input int odo,
                       input int t0, input int t1);
    chk({tag, ".pulse"}, 32'(a_pulse), 32'(pulse));
    chk({tag, ".frac"},  32'(a_frac),  32'(frac));
    chk({tag, ".odo"},   32'(a_odo),   32'(odo));
    chk({tag, ".trip0"}, 32'(a_trip[0 +: 14]),  32'(t0));
    chk({tag, ".trip1"}, 32'(a_trip[14 +: 14]), 32'(t1));
  endtask

  initial begin
    step(3);
    chk_a("reset", 0, 0, 0, 0, 0);

    // 1: velocity 100 -> unit after 360 ticks, tick every 4 clk
    rst_n = 1'b1; a_en = 1'b1; a_vel = 7'd100;
    step(3);
    chk("first_tick_pre", 32'(a_frac), 32'd0);
    step(1);
    chk("first_tick", 32'(a_frac), 32'd100);
    step(1435);
    chk_a("pre_unit1", 0, 35900, 0, 0, 0);
    step(1);
    chk_a("unit1", 1, 0, 1, 1, 1);
    a_vel = 7'd127;
    step(1);
    chk("pulse_one_clk", 32'(a_pulse), 32'd0);

    // 2: velocity 127 -> no unit on tick 283, unit on tick 284 with remainder 68
    step(1131);
    chk_a("tick283", 0, 35941, 1, 1, 1);
    step(4);
    chk_a("tick284", 1, 68, 2, 2, 2);

    // velocity changes between ticks are ignored
    a_vel = 7'd5;
    step(2);
    a_vel = 7'd127;
    step(1129);
    chk_a("pre_unit3", 0, 35882, 2, 2, 2);

    // 4: clear trip0 on the edge carrying a unit
    a_clr = 2'b01;
    step(1);
    chk_a("clr_on_unit", 1, 9, 3, 0, 3);
    a_clr = 2'b00;

    // 6: en=0 for 10 clk holds everything while trip_clr[1] still works
    step(2);
    a_en = 1'b0; a_clr = 2'b10;
    step(10);
    chk_a("hold", 0, 9, 3, 0, 0);
    a_en = 1'b1; a_clr = 2'b00;
    step(1);
    chk("resume_no_tick", 32'(a_frac), 32'd9);
    step(1);
    chk("resume_tick", 32'(a_frac), 32'd136);

    // 5: async reset mid-count
    rst_n = 1'b0;
    #2;
    chk_a("async_rst1", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; a_vel = 7'd100;
    step(802);
    chk_a("mid_count", 0, 20000, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk_a("async_rst2", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(3);
    chk("rel_no_tick", 32'(a_frac), 32'd0);
    step(1);
    chk("rel_tick", 32'(a_frac), 32'd100);

    // 3: saturating odometer and trip wrap on the small instance
    b_en = 1'b1; b_vel = 7'd100;
    npulse = 0;
    for (int i = 0; i < 34; i++) begin
      step(1);
      if (b_pulse) npulse++;
    end
    chk("b_pulses", 32'(npulse), 32'd17);
    chk("b_pulse_last", 32'(b_pulse), 32'd1);
    chk("b_frac", 32'(b_frac), 32'd0);
    chk("b_odo_sat", 32'(b_odo), 32'd15);
    chk("b_trip0", 32'(b_trip[0 +: 5]), 32'd17);
    chk("b_trip1", 32'(b_trip[5 +: 5]), 32'd17);
    step(6);
    chk("b_odo_hold", 32'(b_odo), 32'd15);
    chk("b_trip0_wrap", 32'(b_trip[0 +: 5]), 32'd0);
    chk("b_trip1_wrap", 32'(b_trip[5 +: 5]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
